// File: rtl/serial_mag_cmp_pkg.sv
// serial_mag_cmp_pkg
//   Shared types and constants for the bit-serial magnitude comparator.
//   cmp_state_t  : controller states (IDLE, SHIFT, DONE)
//   cmp_result_t : one-hot lt/eq/gt result bundle
//   CMP_MAX_WIDTH: largest supported operand width
package serial_mag_cmp_pkg;

    localparam int unsigned CMP_MAX_WIDTH = 64;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} cmp_state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_result_t;

endpackage

// File: rtl/serial_mag_cmp_if.sv
// serial_mag_cmp_if
//   Handshake bundle for serial_mag_cmp.
//   start/start_ready        : begin-comparison request and idle indication
//   bit_valid/a_bit/b_bit    : MSB-first operand bit pair stream
//   res_valid/res_ready      : result handshake
//   lt/eq/gt                 : one-hot result flags, valid with res_valid
//   modport master : the producer/consumer surrounding the comparator
//   modport slave  : the comparator itself
interface serial_mag_cmp_if;
    import serial_mag_cmp_pkg::*;

    logic start;
    logic start_ready;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic res_valid;
    logic res_ready;
    logic lt;
    logic eq;
    logic gt;

    modport master (
        output start, bit_valid, a_bit, b_bit, res_ready,
        input  start_ready, res_valid, lt, eq, gt
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit, res_ready,
        output start_ready, res_valid, lt, eq, gt
    );

endinterface

// File: rtl/serial_mag_cmp_decide.sv
// serial_mag_cmp_decide
//   Combinational first-difference decision cell.
//   Inputs : a_bit, b_bit  current operand bits
//            decided       a difference has already been seen
//            is_msb        current pair is the first (sign) bit
//            lt_r, gt_r    current stored decision
//   Outputs: decided_nxt, lt_nxt, gt_nxt  updated decision
//   Macro SERIAL_MAG_CMP_SIGNED_EN: when defined, a difference in the sign
//   bit is interpreted two's complement (the operand with a 1 is smaller).
module serial_mag_cmp_decide
    import serial_mag_cmp_pkg::*;
(
    input  logic a_bit,
    input  logic b_bit,
    input  logic decided,
    input  logic is_msb,
    input  logic lt_r,
    input  logic gt_r,
    output logic decided_nxt,
    output logic lt_nxt,
    output logic gt_nxt
);

`ifndef SERIAL_MAG_CMP_SIGNED_EN
    logic unused_is_msb;
    assign unused_is_msb = is_msb;
`endif

    always_comb begin
        decided_nxt = decided;
        lt_nxt      = lt_r;
        gt_nxt      = gt_r;
        // Only the first differing pair matters; later pairs are ignored.
        if (!decided && (a_bit != b_bit)) begin
            decided_nxt = 1'b1;
`ifdef SERIAL_MAG_CMP_SIGNED_EN
            if (is_msb) begin
                lt_nxt = a_bit;
                gt_nxt = b_bit;
            end else begin
                lt_nxt = b_bit;
                gt_nxt = a_bit;
            end
`else
            lt_nxt = b_bit;
            gt_nxt = a_bit;
`endif
        end
    end

endmodule

// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp
//   Bit-serial magnitude comparator. Two WIDTH-bit operands arrive MSB
//   first, one pair per bit_valid beat; the result is offered on a
//   valid/ready handshake as one-hot lt/eq/gt.
//   Parameters: WIDTH operand width (2..CMP_MAX_WIDTH), default 8
//   Ports     : clk  rising-edge clock
//               rst  synchronous active-high reset
//               bus  serial_mag_cmp_if.slave (start, bit stream, result)
//   Macro SERIAL_MAG_CMP_SIGNED_EN selects two's complement comparison;
//   the port list is the same in both builds.
module serial_mag_cmp
    import serial_mag_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    serial_mag_cmp_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > CMP_MAX_WIDTH) begin : g_width_check
        $error("serial_mag_cmp: WIDTH out of range");
    end

    cmp_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             decided, decided_nxt;
    logic             lt_r, lt_nxt;
    logic             gt_r, gt_nxt;

    logic             cell_decided, cell_lt, cell_gt;
    logic             start_ready;
    logic             res_valid;
    cmp_result_t      result;

    serial_mag_cmp_decide u_decide (
        .a_bit       (bus.a_bit),
        .b_bit       (bus.b_bit),
        .decided     (decided),
        .is_msb      (cnt == '0),
        .lt_r        (lt_r),
        .gt_r        (gt_r),
        .decided_nxt (cell_decided),
        .lt_nxt      (cell_lt),
        .gt_nxt      (cell_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            decided <= 1'b0;
            lt_r    <= 1'b0;
            gt_r    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            decided <= decided_nxt;
            lt_r    <= lt_nxt;
            gt_r    <= gt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        decided_nxt = decided;
        lt_nxt      = lt_r;
        gt_nxt      = gt_r;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        result      = '0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (bus.start) begin
                    state_nxt   = SHIFT;
                    cnt_nxt     = '0;
                    decided_nxt = 1'b0;
                    lt_nxt      = 1'b0;
                    gt_nxt      = 1'b0;
                end
            end
            SHIFT: begin
                if (bus.bit_valid) begin
                    cnt_nxt     = cnt + CNT_W'(1);
                    decided_nxt = cell_decided;
                    lt_nxt      = cell_lt;
                    gt_nxt      = cell_gt;
                    if (cnt == LAST_IDX) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                res_valid = 1'b1;
                result    = '{lt: lt_r, eq: ~decided, gt: gt_r};
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.start_ready = start_ready;
    assign bus.res_valid   = res_valid;
    assign bus.lt          = result.lt;
    assign bus.eq          = result.eq;
    assign bus.gt          = result.gt;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb_serial_mag_cmp
//   Self-checking bench for serial_mag_cmp (WIDTH=8). Expected flags come
//   from integer comparison of the whole operands; expected latency from
//   the bit count plus inserted idle beats.
module tb_serial_mag_cmp;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    serial_mag_cmp_if bus ();

    serial_mag_cmp #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: {lt,eq,gt} from whole-operand comparison.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_MAG_CMP_SIGNED_EN
        if ($signed(a) < $signed(b)) return 3'b100;
        if ($signed(a) > $signed(b)) return 3'b001;
        return 3'b010;
`else
        if (a < b) return 3'b100;
        if (a > b) return 3'b001;
        return 3'b010;
`endif
    endfunction

    function automatic logic [2:0] flags();
        return {bus.lt, bus.eq, bus.gt};
    endfunction

    // Runs one comparison starting at the current negedge; returns the
    // cycle index (start-accept cycle = 0) in which res_valid is first seen.
    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int gap_pos, input int gap_len, input int gap_pct,
                          output int cycles, output int gaps);
        int edges;
        edges = 0;
        gaps  = 0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < W; i++) begin
            int g;
            g = (i == gap_pos) ? gap_len : 0;
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct)
                g += int'($urandom_range(3, 1));
            repeat (g) begin
                bus.bit_valid = 1'b0;
                bus.a_bit = 1'($urandom);
                bus.b_bit = 1'($urandom);
                @(posedge clk);
                edges++;
                gaps++;
                @(negedge clk);
                checks++;
                if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b0 || flags() !== 3'b000) begin
                    errors++;
                    $display("FAIL shift_gap: res_valid=%b start_ready=%b flags=%b required 0 0 000",
                             bus.res_valid, bus.start_ready, flags());
                end
            end
            bus.bit_valid = 1'b1;
            bus.a_bit = a[W-1-i];
            bus.b_bit = b[W-1-i];
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (i < W - 1) begin
                checks++;
                if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b0 || flags() !== 3'b000) begin
                    errors++;
                    $display("FAIL shift_outputs bit %0d: res_valid=%b start_ready=%b flags=%b required 0 0 000",
                             i, bus.res_valid, bus.start_ready, flags());
                end
            end
        end
        bus.bit_valid = 1'b0;
        while (bus.res_valid !== 1'b1 && edges < W + gaps + 8) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checks++;
        if (bus.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL res_timeout: res_valid=%b required 1", bus.res_valid);
        end
        cycles = edges + 1;
    endtask

    task automatic do_ack();
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.bit_valid = 1'b0;
        bus.a_bit = 1'b0;
        bus.b_bit = 1'b0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || flags() !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: start_ready=%b res_valid=%b flags=%b required 1 0 000",
                     bus.start_ready, bus.res_valid, flags());
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic [2:0]   ve [3];
        int cyc, gp;
        va = '{8'h35, 8'hA5, 8'h80};
        vb = '{8'h36, 8'hA5, 8'h7F};
`ifdef SERIAL_MAG_CMP_SIGNED_EN
        ve = '{3'b100, 3'b010, 3'b100};
`else
        ve = '{3'b100, 3'b010, 3'b001};
`endif
        for (int k = 0; k < 3; k++) begin
            do_cmp(va[k], vb[k], -1, 0, 0, cyc, gp);
            checks++;
            if (cyc !== W + 1) begin
                errors++;
                $display("FAIL directed_latency %0d: cycles=%0d required %0d", k, cyc, W + 1);
            end
            checks++;
            if (flags() !== ve[k]) begin
                errors++;
                $display("FAIL directed_flags a=%h b=%h: flags=%b required %b", va[k], vb[k], flags(), ve[k]);
            end
            do_ack();
            checks++;
            if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_idle: start_ready=%b res_valid=%b required 1 0",
                         bus.start_ready, bus.res_valid);
            end
        end
    endtask

    task automatic test_gap();
        int cyc, gp;
        logic [2:0] exp;
`ifdef SERIAL_MAG_CMP_SIGNED_EN
        exp = 3'b100;
`else
        exp = 3'b001;
`endif
        do_cmp(8'hF0, 8'h0F, 3, 3, 0, cyc, gp);
        checks++;
        if (cyc !== W + 1 + 3) begin
            errors++;
            $display("FAIL gap_latency: cycles=%0d required %0d", cyc, W + 4);
        end
        checks++;
        if (flags() !== exp) begin
            errors++;
            $display("FAIL gap_flags: flags=%b required %b", flags(), exp);
        end
        do_ack();
    endtask

    task automatic test_hold();
        int cyc, gp;
        do_cmp(8'h12, 8'h34, -1, 0, 0, cyc, gp);
        repeat (5) begin
            bus.start = 1'b1;
            bus.bit_valid = 1'b1;
            bus.a_bit = 1'($urandom);
            bus.b_bit = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.res_valid !== 1'b1 || flags() !== 3'b100 || bus.start_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: res_valid=%b flags=%b start_ready=%b required 1 100 0",
                         bus.res_valid, flags(), bus.start_ready);
            end
        end
        bus.start = 1'b0;
        bus.bit_valid = 1'b0;
        do_ack();
        checks++;
        if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || flags() !== 3'b000) begin
            errors++;
            $display("FAIL hold_release: start_ready=%b res_valid=%b flags=%b required 1 0 000",
                     bus.start_ready, bus.res_valid, flags());
        end
    endtask

    task automatic test_back_to_back();
        int cyc, gp;
        logic [W-1:0] a, b;
        // start coincident with the result handshake must be ignored
        a = W'($urandom);
        b = W'($urandom);
        do_cmp(a, b, -1, 0, 0, cyc, gp);
        bus.start = 1'b1;
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.start_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_with_handshake: start_ready=%b required 1", bus.start_ready);
        end
        // start in the cycle right after each handshake
        for (int k = 0; k < 3; k++) begin
            a = W'($urandom);
            b = (k == 1) ? a : W'($urandom);
            do_cmp(a, b, -1, 0, 0, cyc, gp);
            checks++;
            if (flags() !== model(a, b) || cyc !== W + 1) begin
                errors++;
                $display("FAIL back_to_back a=%h b=%h: flags=%b cycles=%0d required %b %0d",
                         a, b, flags(), cyc, model(a, b), W + 1);
            end
            do_ack();
        end
    endtask

    task automatic test_reset_mid();
        int cyc, gp;
        int seen;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin
            bus.bit_valid = 1'b1;
            bus.a_bit = 1'b1;
            bus.b_bit = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || flags() !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_state: start_ready=%b res_valid=%b flags=%b required 1 0 000",
                     bus.start_ready, bus.res_valid, flags());
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1) seen++;
        end
        bus.bit_valid = 1'b0;
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_idle: bad cycles=%0d required 0", seen);
        end
        do_cmp(8'h01, 8'h02, -1, 0, 0, cyc, gp);
        checks++;
        if (flags() !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_fresh: flags=%b required 100", flags());
        end
        do_ack();
    endtask

    task automatic test_random();
        int cyc, gp, wait_n;
        logic [W-1:0] a, b;
        logic [2:0] exp;
        for (int n = 0; n < 40; n++) begin
            a = W'($urandom);
            case (n % 4)
                0: b = a;
                1: b = a ^ W'(1);
                2: b = a ^ (W'(1) << (W - 1));
                default: b = W'($urandom);
            endcase
            exp = model(a, b);
            do_cmp(a, b, -1, 0, 30, cyc, gp);
            checks++;
            if (flags() !== exp) begin
                errors++;
                $display("FAIL random_flags a=%h b=%h: flags=%b required %b", a, b, flags(), exp);
            end
            checks++;
            if (cyc !== W + 1 + gp) begin
                errors++;
                $display("FAIL random_latency: cycles=%0d required %0d", cyc, W + 1 + gp);
            end
            checks++;
            if (!$onehot(flags())) begin
                errors++;
                $display("FAIL random_onehot: flags=%b required one-hot", flags());
            end
            wait_n = int'($urandom_range(3));
            repeat (wait_n) begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (bus.res_valid !== 1'b1 || flags() !== exp) begin
                    errors++;
                    $display("FAIL random_hold: res_valid=%b flags=%b required 1 %b",
                             bus.res_valid, flags(), exp);
                end
            end
            do_ack();
        end
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_gap();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_mag_cmp.md
Name: serial_mag_cmp

Overview:
- Bit-serial magnitude comparator; the sequential counterpart of the team's combinational a/b comparators.
- Accepts two WIDTH-bit operands streamed MSB-first, one bit pair per accepted beat.
- Decides lt/eq/gt with a sticky first-difference rule.
- Presents the result on a valid/ready handshake.
- Sits behind a serial link deserializer wherever full-width operands are not available.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to begin a new comparison.
- start_ready  output  1  block idle and able to accept start.
- bit_valid  input  1  a_bit/b_bit carry a valid bit pair this cycle.
- a_bit  input  1  current bit of operand a, MSB first.
- b_bit  input  1  current bit of operand b, MSB first.
- res_valid  output  1  result flags valid.
- res_ready  input  1  consumer accepts the result.
- lt  output  1  a < b.
- eq  output  1  a == b.
- gt  output  1  a > b.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: state=IDLE, start_ready=1, res_valid=0, lt=0, eq=0, gt=0, bit counter=0, decided=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - start=1 -> SHIFT next cycle; clears counter, decided, lt_r and gt_r.
  - bit_valid is ignored.
- SHIFT:
  - start_ready=0.
  - Each cycle with bit_valid=1 consumes one pair and increments the counter (width $clog2(WIDTH+1)).
  - If decided=0 and a_bit!=b_bit: set decided=1, lt_r=b_bit, gt_r=a_bit.
  - Once decided=1, later bits never change lt_r/gt_r.
  - Cycles with bit_valid=0 consume nothing; gaps of any length are legal.
  - The edge consuming bit WIDTH moves the FSM to DONE.
- DONE:
  - res_valid=1; lt=lt_r, gt=gt_r, eq=~decided.
  - Outputs held stable until res_ready=1.
  - res_valid & res_ready -> IDLE next cycle.
  - start and bit_valid are ignored.
  - start_ready=0.
- Outside DONE: lt, eq and gt are forced to 0.
- Latency: res_valid rises in the cycle after the edge that consumes the WIDTH-th bit. With no gaps, that is WIDTH+1 cycles after start is accepted.
- Throughput: back-to-back start is allowed in the cycle following the res handshake, i.e. one comparison per WIDTH+2 cycles minimum.
- Simultaneous events:
  - start in the same cycle as the res handshake is ignored, because the FSM is not yet in IDLE.
  - rst has priority over everything.
- Reset mid-operation (any state): return to IDLE next edge with reset values; partial result discarded; no res_valid pulse.
- Exactly one of lt/eq/gt is 1 whenever res_valid=1.

Optional Feature:
- Macro: SERIAL_MAG_CMP_SIGNED_EN.
- Defined: operands are two's complement. At the first bit (counter=0, the sign bit), a difference sets lt_r=a_bit and gt_r=b_bit, inverted relative to unsigned. All later bits use the unsigned rule.
- Undefined: unsigned comparison for every bit; no sign logic synthesized.
- Port list is identical in both builds.

Decomposition:
- Package serial_mag_cmp_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} cmp_state_t;
  - typedef struct packed {logic lt; logic eq; logic gt;} cmp_result_t;
  - constant CMP_MAX_WIDTH=64.
- One sub-module: serial_mag_cmp_decide, a combinational cell.
  - Inputs: a_bit, b_bit, decided, is_msb, and the current lt_r/gt_r.
  - Outputs: next decided, lt_r, gt_r.
  - The signed/unsigned macro affects only this cell.

Test Plan:
1. WIDTH=8, a=0x35, b=0x36, bits driven with no gaps -> res_valid at cycle 9 after start accepted; lt=1, eq=0, gt=0.
2. a=b=0xA5 -> eq=1, lt=0, gt=0.
3. a=0x80, b=0x7F -> unsigned build: gt=1; build with SERIAL_MAG_CMP_SIGNED_EN: lt=1.
4. a=0xF0, b=0x0F with bit_valid low for 3 cycles between bits 2 and 3 -> gt=1; res_valid delayed by exactly 3 cycles versus the gapless case.
5. Hold res_ready=0 for 5 cycles in DONE while pulsing start and bit_valid -> res_valid and flags stable, start_ready=0. Raise res_ready -> IDLE next cycle with start_ready=1.
6. Assert rst for 1 cycle after 3 bits consumed -> next cycle IDLE, start_ready=1, flags 0. A fresh a=0x01, b=0x02 comparison then yields lt=1.
